grf_hazard_ctrl: RTL and testbench

- Scheduler for the general register file in the 5-stage pipeline.
- Tracks destination tags of in-flight instructions in E/M/W and computes the D-stage stall.
- Produces forwarding selects for GRF read ports at D and at E, and sequences the multi-cycle mult/div unit's busy window.
- Sits beside decode; drives pipeline-register enables and the operand muxes in front of the GRF outputs.

---
 rtl/grf_hazard_ctrl.sv | 96 +++++++++
 tb/tb_grf_hazard_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/grf_hazard_ctrl.sv
// grf_hazard_ctrl: GRF stall/forwarding scheduler with mult/div busy sequencer; define HAZARD_TRACE_EN for a stall/forward trace
module grf_hazard_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] rs_d,
    input  logic [4:0] rt_d,
    input  logic [1:0] tuse_rs_d,
    input  logic [1:0] tuse_rt_d,
    input  logic [4:0] dst_d,
    input  logic       wr_d,
    input  logic [1:0] tnew_d,
    input  logic       md_use_d,
    input  logic       md_start_e,
    input  logic       md_div_e,
    output logic       stall,
    output logic [1:0] fwd_rs_d,
    output logic [1:0] fwd_rt_d,
    output logic [1:0] fwd_rs_e,
    output logic [1:0] fwd_rt_e,
    output logic       md_busy
);
    typedef struct packed {
        logic       v;
        logic [4:0] a;
        logic [1:0] t;
    } tag_t;

    tag_t       e_q, e_d, m_q, m_d, w_q, w_d;
    logic [4:0] rs_e_q, rs_e_d, rt_e_q, rt_e_d;
    logic [3:0] md_q, md_d;
    logic       raw_rs, raw_rt, md_hold;

    function automatic logic hit(input tag_t s, input logic [4:0] a);
        return s.v && s.a == a && a != 5'd0;
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] t);
        return t == 2'd0 ? 2'd0 : t - 2'd1;
    endfunction

    // Stall when an E/M producer cannot deliver before D consumes, or HI/LO is still pending
    always_comb begin
        raw_rs   = (hit(e_q, rs_d) && e_q.t > tuse_rs_d) || (hit(m_q, rs_d) && m_q.t > tuse_rs_d);
        raw_rt   = (hit(e_q, rt_d) && e_q.t > tuse_rt_d) || (hit(m_q, rt_d) && m_q.t > tuse_rt_d);
        md_hold  = md_use_d && (md_start_e || md_busy);
        stall    = !reset && (raw_rs || raw_rt || md_hold);
        md_busy  = md_q != 4'd0;
        fwd_rs_d = hit(e_q, rs_d) && e_q.t == 2'd0 ? 2'd1 : hit(m_q, rs_d) && m_q.t == 2'd0 ? 2'd2 : 2'd0;
        fwd_rt_d = hit(e_q, rt_d) && e_q.t == 2'd0 ? 2'd1 : hit(m_q, rt_d) && m_q.t == 2'd0 ? 2'd2 : 2'd0;
        fwd_rs_e = hit(m_q, rs_e_q) && m_q.t == 2'd0 ? 2'd1 : hit(w_q, rs_e_q) ? 2'd2 : 2'd0;
        fwd_rt_e = hit(m_q, rt_e_q) && m_q.t == 2'd0 ? 2'd1 : hit(w_q, rt_e_q) ? 2'd2 : 2'd0;
    end

    // Advance tags down the pipe, ageing tnew; a stall injects a bubble into E
    always_comb begin
        e_d    = stall ? tag_t'(8'd0) : {wr_d && dst_d != 5'd0, dst_d, tnew_d};
        m_d    = {e_q.v, e_q.a, sat_dec(e_q.t)};
        w_d    = {m_q.v, m_q.a, 2'd0};
        rs_e_d = stall ? 5'd0 : rs_d;
        rt_e_d = stall ? 5'd0 : rt_d;
        md_d   = md_start_e ? (md_div_e ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES)) : md_q - {3'd0, md_q != 4'd0};
    end

    // State registers, cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_q    <= '0;
            m_q    <= '0;
            w_q    <= '0;
            rs_e_q <= '0;
            rt_e_q <= '0;
            md_q   <= '0;
        end else begin
            e_q    <= e_d;
            m_q    <= m_d;
            w_q    <= w_d;
            rs_e_q <= rs_e_d;
            rt_e_q <= rt_e_d;
            md_q   <= md_d;
        end
    end

`ifdef HAZARD_TRACE_EN
    // Trace stalls and every active forwarding select
    always @(posedge clk) begin
        if (stall && !reset) $display("%d@stall: rs=%d rt=%d md=%b", $time, rs_d, rt_d, md_busy);
        if (fwd_rs_d != 2'd0) $display("%d@fwd rs_d from %s", $time, fwd_rs_d == 2'd1 ? "E" : "M");
        if (fwd_rt_d != 2'd0) $display("%d@fwd rt_d from %s", $time, fwd_rt_d == 2'd1 ? "E" : "M");
        if (fwd_rs_e != 2'd0) $display("%d@fwd rs_e from %s", $time, fwd_rs_e == 2'd1 ? "M" : "W");
        if (fwd_rt_e != 2'd0) $display("%d@fwd rt_e from %s", $time, fwd_rt_e == 2'd1 ? "M" : "W");
    end
`endif
endmodule

// File: tb/tb_grf_hazard_ctrl.sv
// tb_grf_hazard_ctrl: directed scenarios plus randomized run against a cycle-stamped pipeline model
module tb_grf_hazard_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] rs_d, rt_d, dst_d;
    logic [1:0] tuse_rs_d, tuse_rt_d, tnew_d;
    logic       wr_d, md_use_d, md_start_e, md_div_e;
    logic       stall, md_busy;
    logic [1:0] fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;
    int         total = 0;
    int         bad = 0;

    // model: slot 0=E, 1=M, 2=W; result readiness kept as an absolute cycle number
    bit mv[3];
    int mdst[3];
    int mready[3];
    int m_rs_e, m_rt_e, now, md_free;

    grf_hazard_ctrl dut (
        .clk(clk), .reset(reset), .rs_d(rs_d), .rt_d(rt_d), .tuse_rs_d(tuse_rs_d),
        .tuse_rt_d(tuse_rt_d), .dst_d(dst_d), .wr_d(wr_d), .tnew_d(tnew_d),
        .md_use_d(md_use_d), .md_start_e(md_start_e), .md_div_e(md_div_e), .stall(stall),
        .fwd_rs_d(fwd_rs_d), .fwd_rt_d(fwd_rt_d), .fwd_rs_e(fwd_rs_e), .fwd_rt_e(fwd_rt_e),
        .md_busy(md_busy)
    );

    always #5 clk = ~clk;

    function automatic int tn(int s);
        return mready[s] - now > 0 ? mready[s] - now : 0;
    endfunction

    function automatic bit mhit(int s, int a);
        return mv[s] && mdst[s] == a && a != 0;
    endfunction

    task automatic drv(input logic [4:0] rs, rt, input logic [1:0] urs, urt,
                       input logic [4:0] dst, input logic wr, input logic [1:0] tw,
                       input logic mu, ms, mdv);
        rs_d = rs; rt_d = rt; tuse_rs_d = urs; tuse_rt_d = urt;
        dst_d = dst; wr_d = wr; tnew_d = tw;
        md_use_d = mu; md_start_e = ms; md_div_e = mdv;
    endtask

    task automatic idle();
        drv(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drv(5'd8, 5'd8, 2'd0, 2'd0, 5'd8, 1'b1, 2'd2, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        #1;
        total++;
        if ({stall, md_busy, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e} !== 10'd0) begin
            bad++;
            $display("FAIL reset_outputs: got %b want 0", {stall, md_busy, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e});
        end
        do_reset();
        #1;
        total++;
        if ({stall, md_busy, fwd_rs_e, fwd_rt_e} !== 6'd0) begin
            bad++;
            $display("FAIL post_reset_idle: got %b want 0", {stall, md_busy, fwd_rs_e, fwd_rt_e});
        end
    endtask

    task automatic test_load_use();
        do_reset();
        drv(5'd0, 5'd0, 2'd3, 2'd3, 5'd8, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
        #1;
        total++;
        if (stall !== 1'b0) begin bad++; $display("FAIL lu_producer_stall: got %b want 0", stall); end
        @(negedge clk);
        drv(5'd8, 5'd0, 2'd1, 2'd3, 5'd9, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0);
        #1;
        total++;
        if (stall !== 1'b1) begin bad++; $display("FAIL lu_stall: got %b want 1", stall); end
        @(negedge clk);
        #1;
        total++;
        if (stall !== 1'b0) begin bad++; $display("FAIL lu_stall_release: got %b want 0", stall); end
        total++;
        if (fwd_rs_d !== 2'd0) begin bad++; $display("FAIL lu_fwd_rs_d: got %0d want 0", fwd_rs_d); end
        @(negedge clk);
        idle();
        #1;
        total++;
        if (fwd_rs_e !== 2'd2) begin bad++; $display("FAIL lu_fwd_rs_e: got %0d want 2", fwd_rs_e); end
    endtask

    task automatic test_alu_b2b();
        do_reset();
        drv(5'd0, 5'd0, 2'd3, 2'd3, 5'd5, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        drv(5'd0, 5'd5, 2'd3, 2'd1, 5'd6, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
        #1;
        total++;
        if (stall !== 1'b0) begin bad++; $display("FAIL alu_stall: got %b want 0", stall); end
        total++;
        if (fwd_rt_d !== 2'd0) begin bad++; $display("FAIL alu_fwd_rt_d: got %0d want 0", fwd_rt_d); end
        @(negedge clk);
        idle();
        #1;
        total++;
        if (fwd_rt_e !== 2'd1) begin bad++; $display("FAIL alu_fwd_rt_e: got %0d want 1", fwd_rt_e); end
    endtask

    task automatic test_branch();
        do_reset();
        drv(5'd0, 5'd0, 2'd3, 2'd3, 5'd3, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        drv(5'd3, 5'd0, 2'd0, 2'd0, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        #1;
        total++;
        if (stall !== 1'b1) begin bad++; $display("FAIL br_stall: got %b want 1", stall); end
        @(negedge clk);
        #1;
        total++;
        if (stall !== 1'b0) begin bad++; $display("FAIL br_stall_release: got %b want 0", stall); end
        total++;
        if (fwd_rs_d !== 2'd2) begin bad++; $display("FAIL br_fwd_rs_d: got %0d want 2", fwd_rs_d); end
    endtask

    task automatic test_zero();
        do_reset();
        drv(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        drv(5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
        #1;
        total++;
        if ({stall, fwd_rs_d, fwd_rt_d} !== 5'd0) begin
            bad++;
            $display("FAIL zero_d: got %b want 0", {stall, fwd_rs_d, fwd_rt_d});
        end
        @(negedge clk);
        idle();
        #1;
        total++;
        if ({fwd_rs_e, fwd_rt_e} !== 4'd0) begin bad++; $display("FAIL zero_e: got %b want 0", {fwd_rs_e, fwd_rt_e}); end
    endtask

    task automatic test_muldiv();
        do_reset();
        drv(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b1);
        #1;
        total++;
        if ({stall, md_busy} !== 2'b10) begin bad++; $display("FAIL md_start: got %b want 10", {stall, md_busy}); end
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            md_start_e = 1'b0;
            #1;
            total++;
            if ({stall, md_busy} !== 2'b11) begin
                bad++;
                $display("FAIL md_busy_c%0d: got %b want 11", k, {stall, md_busy});
            end
        end
        @(negedge clk);
        #1;
        total++;
        if ({stall, md_busy} !== 2'b00) begin bad++; $display("FAIL md_done: got %b want 00", {stall, md_busy}); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        drv(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        drv(5'd0, 5'd0, 2'd3, 2'd3, 5'd8, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        drv(5'd8, 5'd0, 2'd0, 2'd3, 5'd0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
        #1;
        total++;
        if ({stall, md_busy} !== 2'b11) begin bad++; $display("FAIL rm_before: got %b want 11", {stall, md_busy}); end
        #2;
        reset = 1'b1;
        #1;
        total++;
        if ({stall, md_busy, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e} !== 10'd0) begin
            bad++;
            $display("FAIL rm_async: got %b want 0", {stall, md_busy, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e});
        end
        @(negedge clk);
        reset = 1'b0;
        idle();
    endtask

    task automatic test_random();
        bit x_st, busy;
        logic [1:0] x_frd, x_ftd, x_fre, x_fte;
        do_reset();
        mv = '{0, 0, 0};
        m_rs_e = 0; m_rt_e = 0; now = 0; md_free = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            drv(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                2'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                2'($urandom_range(0, 2)), $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
                1'($urandom_range(0, 1)));
            #1;
            busy = now < md_free;
            x_st = 0;
            for (int s = 0; s < 2; s++)
                x_st |= (mhit(s, rs_d) && tn(s) > tuse_rs_d) || (mhit(s, rt_d) && tn(s) > tuse_rt_d);
            x_st |= md_use_d && (md_start_e || busy);
            x_frd = mhit(0, rs_d) && tn(0) == 0 ? 2'd1 : mhit(1, rs_d) && tn(1) == 0 ? 2'd2 : 2'd0;
            x_ftd = mhit(0, rt_d) && tn(0) == 0 ? 2'd1 : mhit(1, rt_d) && tn(1) == 0 ? 2'd2 : 2'd0;
            x_fre = mhit(1, m_rs_e) && tn(1) == 0 ? 2'd1 : mhit(2, m_rs_e) ? 2'd2 : 2'd0;
            x_fte = mhit(1, m_rt_e) && tn(1) == 0 ? 2'd1 : mhit(2, m_rt_e) ? 2'd2 : 2'd0;
            total++;
            if (stall !== x_st) begin bad++; $display("FAIL rnd_stall@%0d: got %b want %b", i, stall, x_st); end
            total++;
            if (md_busy !== busy) begin bad++; $display("FAIL rnd_busy@%0d: got %b want %b", i, md_busy, busy); end
            total++;
            if (fwd_rs_d !== x_frd) begin bad++; $display("FAIL rnd_fwd_rs_d@%0d: got %0d want %0d", i, fwd_rs_d, x_frd); end
            total++;
            if (fwd_rt_d !== x_ftd) begin bad++; $display("FAIL rnd_fwd_rt_d@%0d: got %0d want %0d", i, fwd_rt_d, x_ftd); end
            total++;
            if (fwd_rs_e !== x_fre) begin bad++; $display("FAIL rnd_fwd_rs_e@%0d: got %0d want %0d", i, fwd_rs_e, x_fre); end
            total++;
            if (fwd_rt_e !== x_fte) begin bad++; $display("FAIL rnd_fwd_rt_e@%0d: got %0d want %0d", i, fwd_rt_e, x_fte); end
            if (md_start_e) md_free = now + 1 + (md_div_e ? 10 : 5);
            for (int s = 2; s > 0; s--) begin
                mv[s] = mv[s-1]; mdst[s] = mdst[s-1]; mready[s] = mready[s-1];
            end
            mv[0] = !x_st && wr_d;
            mdst[0] = dst_d;
            mready[0] = now + 1 + int'(tnew_d);
            m_rs_e = x_st ? 0 : int'(rs_d);
            m_rt_e = x_st ? 0 : int'(rt_d);
            now++;
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_load_use();
        test_alu_b2b();
        test_branch();
        test_zero();
        test_muldiv();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
